// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: request types, read owner IDs,
// and the read/write FSM state types.
package mem_bus_arbiter_pkg;

   localparam logic [2:0] RD_TYPE_WORD = 3'b010;
   localparam logic [2:0] RD_TYPE_LINE = 3'b100;

   localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
   localparam logic [2:0] WR_TYPE_HALF = 3'b001;
   localparam logic [2:0] WR_TYPE_WORD = 3'b010;
   localparam logic [2:0] WR_TYPE_LINE = 3'b100;

   localparam logic OWNER_IC = 1'b0;
   localparam logic OWNER_DC = 1'b1;

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;

endpackage

// File: rtl/mem_bus_arbiter_streak.sv
// Read grant selection: DCache first, but after MAX_STREAK DCache grants
// with an ICache read waiting, the ICache gets the next grant.
module streak_arbiter #(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic ic_req,
   input  logic ic_elig,
   input  logic dc_req,
   input  logic dc_elig,
   output logic gnt_ic,
   output logic gnt_dc
);

   localparam int unsigned CW = $clog2(MAX_STREAK + 1);

   logic [CW-1:0] streak_q, streak_d;
   logic          at_max;
   logic          ic_ok, dc_ok;

   assign at_max = (streak_q == CW'(MAX_STREAK));
   assign ic_ok  = ic_req & ic_elig;
   assign dc_ok  = dc_req & dc_elig;

   always_comb begin
      gnt_ic   = 1'b0;
      gnt_dc   = 1'b0;
      streak_d = streak_q;
      if (en) begin
         if (ic_ok && (at_max || !dc_ok)) gnt_ic = 1'b1;
         else if (dc_ok)                  gnt_dc = 1'b1;
      end
      if (!ic_req || gnt_ic)       streak_d = '0;
      else if (gnt_dc && !at_max)  streak_d = streak_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) streak_q <= '0;
      else         streak_q <= streak_d;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between ICache reads and DCache reads/writes; reads
// and writes run on independent FSMs, with reads held off lines being written.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_OFF_W = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ic_rd_req,
   input  logic [2:0]        ic_rd_type,
   input  logic [ADDR_W-1:0] ic_rd_addr,
   output logic              ic_rd_rdy,
   output logic              ic_ret_valid,
   output logic              ic_ret_last,
   output logic [31:0]       ic_ret_data,
   input  logic              dc_rd_req,
   input  logic [2:0]        dc_rd_type,
   input  logic [ADDR_W-1:0] dc_rd_addr,
   output logic              dc_rd_rdy,
   output logic              dc_ret_valid,
   output logic              dc_ret_last,
   output logic [31:0]       dc_ret_data,
   input  logic              dc_wr_req,
   input  logic [2:0]        dc_wr_type,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [3:0]        dc_wr_wstrb,
   input  logic [127:0]      dc_wr_data,
   output logic              dc_wr_rdy,
   output logic              mem_rd_req,
   output logic              mem_rd_id,
   output logic [2:0]        mem_rd_type,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_rdy,
   input  logic              mem_ret_valid,
   input  logic              mem_ret_last,
   input  logic [31:0]       mem_ret_data,
   output logic              mem_wr_req,
   output logic [2:0]        mem_wr_type,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [3:0]        mem_wr_wstrb,
   output logic [127:0]      mem_wr_data,
   input  logic              mem_wr_rdy,
   input  logic              mem_wr_done
);

   rd_state_t         r_state_q, r_state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [2:0]        rd_type_q, rd_type_d;
   logic              rd_owner_q, rd_owner_d;

   wr_state_t         w_state_q, w_state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [2:0]        wr_type_q, wr_type_d;
   logic [3:0]        wr_wstrb_q, wr_wstrb_d;
   logic [127:0]      wr_data_q, wr_data_d;

   logic wr_busy, wr_acc, ic_elig, dc_elig, gnt_ic, gnt_dc;

   // Ready strobes are gated by resetn so every output reads 0 while reset is held.
   assign dc_wr_rdy = resetn & (w_state_q == W_IDLE);
   assign wr_busy   = (w_state_q == W_REQ) || (w_state_q == W_RESP);
   assign wr_acc    = dc_wr_req & dc_wr_rdy;

   assign ic_elig = !((wr_busy && ic_rd_addr[ADDR_W-1:LINE_OFF_W] == wr_addr_q[ADDR_W-1:LINE_OFF_W]) ||
                      (wr_acc  && ic_rd_addr[ADDR_W-1:LINE_OFF_W] == dc_wr_addr[ADDR_W-1:LINE_OFF_W]));
   assign dc_elig = !((wr_busy && dc_rd_addr[ADDR_W-1:LINE_OFF_W] == wr_addr_q[ADDR_W-1:LINE_OFF_W]) ||
                      (wr_acc  && dc_rd_addr[ADDR_W-1:LINE_OFF_W] == dc_wr_addr[ADDR_W-1:LINE_OFF_W]));

   streak_arbiter #(.MAX_STREAK(MAX_STREAK)) u_streak (
      .clk     (clk),
      .resetn  (resetn),
      .en      (resetn && r_state_q == R_IDLE),
      .ic_req  (ic_rd_req),
      .ic_elig (ic_elig),
      .dc_req  (dc_rd_req),
      .dc_elig (dc_elig),
      .gnt_ic  (gnt_ic),
      .gnt_dc  (gnt_dc)
   );

   assign ic_rd_rdy   = gnt_ic;
   assign dc_rd_rdy   = gnt_dc;
   assign mem_rd_id   = rd_owner_q;
   assign mem_rd_type = rd_type_q;
   assign mem_rd_addr = rd_addr_q;

   always_comb begin
      r_state_d    = r_state_q;
      rd_addr_d    = rd_addr_q;
      rd_type_d    = rd_type_q;
      rd_owner_d   = rd_owner_q;
      mem_rd_req   = 1'b0;
      ic_ret_valid = 1'b0;
      ic_ret_last  = 1'b0;
      ic_ret_data  = '0;
      dc_ret_valid = 1'b0;
      dc_ret_last  = 1'b0;
      dc_ret_data  = '0;
      case (r_state_q)
         R_IDLE: begin
            if (gnt_ic) begin
               rd_addr_d  = ic_rd_addr;
               rd_type_d  = ic_rd_type;
               rd_owner_d = OWNER_IC;
               r_state_d  = R_REQ;
            end else if (gnt_dc) begin
               rd_addr_d  = dc_rd_addr;
               rd_type_d  = dc_rd_type;
               rd_owner_d = OWNER_DC;
               r_state_d  = R_REQ;
            end
         end
         R_REQ: begin
            mem_rd_req = 1'b1;
            if (mem_rd_rdy) r_state_d = R_DATA;
         end
         R_DATA: begin
            if (rd_owner_q == OWNER_DC) begin
               dc_ret_valid = mem_ret_valid;
               dc_ret_last  = mem_ret_last;
               dc_ret_data  = mem_ret_data;
            end else begin
               ic_ret_valid = mem_ret_valid;
               ic_ret_last  = mem_ret_last;
               ic_ret_data  = mem_ret_data;
            end
            if (mem_ret_valid && mem_ret_last) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign mem_wr_type  = wr_type_q;
   assign mem_wr_addr  = wr_addr_q;
   assign mem_wr_wstrb = wr_wstrb_q;
   assign mem_wr_data  = wr_data_q;

   always_comb begin
      w_state_d  = w_state_q;
      wr_addr_d  = wr_addr_q;
      wr_type_d  = wr_type_q;
      wr_wstrb_d = wr_wstrb_q;
      wr_data_d  = wr_data_q;
      mem_wr_req = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (wr_acc) begin
               wr_addr_d  = dc_wr_addr;
               wr_type_d  = dc_wr_type;
               wr_wstrb_d = dc_wr_wstrb;
               wr_data_d  = dc_wr_data;
               w_state_d  = W_REQ;
            end
         end
         W_REQ: begin
            mem_wr_req = 1'b1;
            if (mem_wr_rdy) w_state_d = W_RESP;
         end
         W_RESP: if (mem_wr_done) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state_q  <= R_IDLE;
         rd_addr_q  <= '0;
         rd_type_q  <= '0;
         rd_owner_q <= 1'b0;
         w_state_q  <= W_IDLE;
         wr_addr_q  <= '0;
         wr_type_q  <= '0;
         wr_wstrb_q <= '0;
         wr_data_q  <= '0;
      end else begin
         r_state_q  <= r_state_d;
         rd_addr_q  <= rd_addr_d;
         rd_type_q  <= rd_type_d;
         rd_owner_q <= rd_owner_d;
         w_state_q  <= w_state_d;
         wr_addr_q  <= wr_addr_d;
         wr_type_q  <= wr_type_d;
         wr_wstrb_q <= wr_wstrb_d;
         wr_data_q  <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the bench plays the memory bus itself.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic         clk = 1'b0;
   logic         resetn;
   logic         ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
   logic [2:0]   ic_rd_type;
   logic [31:0]  ic_rd_addr, ic_ret_data;
   logic         dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
   logic [2:0]   dc_rd_type;
   logic [31:0]  dc_rd_addr, dc_ret_data;
   logic         dc_wr_req, dc_wr_rdy;
   logic [2:0]   dc_wr_type;
   logic [31:0]  dc_wr_addr;
   logic [3:0]   dc_wr_wstrb;
   logic [127:0] dc_wr_data;
   logic         mem_rd_req, mem_rd_id, mem_rd_rdy;
   logic [2:0]   mem_rd_type;
   logic [31:0]  mem_rd_addr;
   logic         mem_ret_valid, mem_ret_last;
   logic [31:0]  mem_ret_data;
   logic         mem_wr_req, mem_wr_rdy, mem_wr_done;
   logic [2:0]   mem_wr_type;
   logic [31:0]  mem_wr_addr;
   logic [3:0]   mem_wr_wstrb;
   logic [127:0] mem_wr_data;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [127:0] WDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   mem_bus_arbiter #(.MAX_STREAK(4), .ADDR_W(32), .LINE_OFF_W(4)) dut (
      .clk(clk), .resetn(resetn),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
      .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
      .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
      .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
      .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
      .mem_rd_req(mem_rd_req), .mem_rd_id(mem_rd_id), .mem_rd_type(mem_rd_type),
      .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
      .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
      .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
      .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
      .mem_wr_done(mem_wr_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered one cycle after an accept (read FSM in R_REQ); serves a burst.
   task automatic do_read(input logic own, input logic [31:0] addr, input logic [2:0] typ,
                          input int unsigned beats, input logic [31:0] d0);
      #1;
      check_eq("rd_req", mem_rd_req, 1'b1);
      check_eq("rd_id", mem_rd_id, own);
      check_eq("rd_addr", mem_rd_addr, addr);
      check_eq("rd_type", mem_rd_type, typ);
      check_eq("busy_rdy", {ic_rd_rdy, dc_rd_rdy}, 2'b00);
      mem_rd_rdy = 1'b1;
      tick();
      mem_rd_rdy = 1'b0;
      for (int unsigned i = 0; i < beats; i++) begin
         mem_ret_valid = 1'b1;
         mem_ret_last  = (i == beats - 1);
         mem_ret_data  = d0 + i;
         #1;
         check_eq("ret_valid", own ? dc_ret_valid : ic_ret_valid, 1'b1);
         check_eq("ret_last",  own ? dc_ret_last  : ic_ret_last, (i == beats - 1));
         check_eq("ret_data",  own ? dc_ret_data  : ic_ret_data, d0 + i);
         check_eq("other_valid", own ? ic_ret_valid : dc_ret_valid, 1'b0);
         tick();
      end
      mem_ret_valid = 1'b0;
      mem_ret_last  = 1'b0;
      mem_ret_data  = '0;
   endtask

   initial begin
      logic exp_ic;
      resetn = 1'b0;
      ic_rd_req = 1'b1; ic_rd_type = '0; ic_rd_addr = '0;
      dc_rd_req = 1'b0; dc_rd_type = '0; dc_rd_addr = '0;
      dc_wr_req = 1'b1; dc_wr_type = '0; dc_wr_addr = '0; dc_wr_wstrb = '0; dc_wr_data = '0;
      mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
      mem_wr_rdy = 1'b0; mem_wr_done = 1'b0;

      // reset state: requests present but everything held at zero
      tick(); tick(); #1;
      check_eq("rst_ic_rdy", ic_rd_rdy, 1'b0);
      check_eq("rst_wr_rdy", dc_wr_rdy, 1'b0);
      check_eq("rst_rd_req", mem_rd_req, 1'b0);
      check_eq("rst_wr_req", mem_wr_req, 1'b0);
      check_eq("rst_rd_addr", mem_rd_addr, 32'h0);
      ic_rd_req = 1'b0; dc_wr_req = 1'b0;
      tick();
      resetn = 1'b1;
      mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hDEAD;
      #1;
      check_eq("idle_wr_rdy", dc_wr_rdy, 1'b1);
      check_eq("stray_ret", {ic_ret_valid, dc_ret_valid}, 2'b00);
      mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
      tick();

      // 1: DCache line read
      dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_LINE; dc_rd_addr = 32'h1000;
      #1;
      check_eq("t1_dc_rdy", dc_rd_rdy, 1'b1);
      check_eq("t1_ic_rdy", ic_rd_rdy, 1'b0);
      tick();
      dc_rd_req = 1'b0;
      do_read(OWNER_DC, 32'h1000, RD_TYPE_LINE, 4, 32'hA0);
      #1;
      check_eq("t1_idle", mem_rd_req, 1'b0);
      tick();

      // 2: streak fairness, expected DC,DC,DC,DC,IC,DC
      ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_WORD; ic_rd_addr = 32'h4000;
      dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_WORD; dc_rd_addr = 32'h5000;
      for (int g = 0; g < 6; g++) begin
         exp_ic = (g == 4);
         #1;
         check_eq($sformatf("t2_ic_rdy%0d", g), ic_rd_rdy, exp_ic);
         check_eq($sformatf("t2_dc_rdy%0d", g), dc_rd_rdy, !exp_ic);
         tick();
         if (exp_ic) do_read(OWNER_IC, 32'h4000, RD_TYPE_WORD, 1, 32'h100 + g);
         else        do_read(OWNER_DC, 32'h5000, RD_TYPE_WORD, 1, 32'h200 + g);
      end
      ic_rd_req = 1'b0; dc_rd_req = 1'b0;
      tick();

      // 3: read of a line under writeback waits; ICache to another line proceeds
      dc_wr_req = 1'b1; dc_wr_type = WR_TYPE_LINE; dc_wr_addr = 32'h2000;
      dc_wr_wstrb = 4'hF; dc_wr_data = WDATA;
      #1;
      check_eq("t3_wr_rdy", dc_wr_rdy, 1'b1);
      tick();
      dc_wr_req = 1'b0;
      dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_WORD; dc_rd_addr = 32'h2008;
      #1;
      check_eq("t3_wr_req", mem_wr_req, 1'b1);
      check_eq("t3_wr_addr", mem_wr_addr, 32'h2000);
      check_eq("t3_wr_type", mem_wr_type, WR_TYPE_LINE);
      check_eq("t3_wr_strb", mem_wr_wstrb, 4'hF);
      check_eq("t3_wr_data", mem_wr_data, WDATA);
      check_eq("t3_wr_busy", dc_wr_rdy, 1'b0);
      check_eq("t3_blk_req", dc_rd_rdy, 1'b0);
      mem_wr_rdy = 1'b1;
      tick();
      mem_wr_rdy = 1'b0;
      ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_WORD; ic_rd_addr = 32'h3000;
      #1;
      check_eq("t3_ic_rdy", ic_rd_rdy, 1'b1);
      check_eq("t3_blk_resp", dc_rd_rdy, 1'b0);
      tick();
      ic_rd_req = 1'b0;
      do_read(OWNER_IC, 32'h3000, RD_TYPE_WORD, 1, 32'h300);
      for (int k = 0; k < 6; k++) begin
         #1;
         check_eq("t3_blk_wait", dc_rd_rdy, 1'b0);
         tick();
      end
      mem_wr_done = 1'b1;
      #1;
      check_eq("t3_blk_done", dc_rd_rdy, 1'b0);
      tick();
      mem_wr_done = 1'b0;
      #1;
      check_eq("t3_unblk", dc_rd_rdy, 1'b1);
      tick();
      dc_rd_req = 1'b0;
      do_read(OWNER_DC, 32'h2008, RD_TYPE_WORD, 1, 32'h400);

      // 4: same-cycle write and read to one line
      dc_wr_req = 1'b1; dc_wr_type = WR_TYPE_LINE; dc_wr_addr = 32'h6000; dc_wr_data = WDATA;
      dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_WORD; dc_rd_addr = 32'h6004;
      #1;
      check_eq("t4_wr_rdy", dc_wr_rdy, 1'b1);
      check_eq("t4_rd_blk", dc_rd_rdy, 1'b0);
      tick();
      dc_wr_req = 1'b0;
      #1;
      check_eq("t4_blk_req", dc_rd_rdy, 1'b0);
      mem_wr_rdy = 1'b1;
      tick();
      mem_wr_rdy = 1'b0;
      mem_wr_done = 1'b1;
      #1;
      check_eq("t4_blk_done", dc_rd_rdy, 1'b0);
      tick();
      mem_wr_done = 1'b0;
      #1;
      check_eq("t4_unblk", dc_rd_rdy, 1'b1);
      tick();
      dc_rd_req = 1'b0;
      do_read(OWNER_DC, 32'h6004, RD_TYPE_WORD, 1, 32'h500);

      // 5: reset during the second beat of an ICache burst
      ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_LINE; ic_rd_addr = 32'h7000;
      #1;
      check_eq("t5_ic_rdy", ic_rd_rdy, 1'b1);
      tick();
      ic_rd_req = 1'b0;
      mem_rd_rdy = 1'b1;
      tick();
      mem_rd_rdy = 1'b0;
      mem_ret_valid = 1'b1; mem_ret_data = 32'hB0;
      tick();
      mem_ret_data = 32'hB1;
      #1;
      check_eq("t5_beat2", ic_ret_data, 32'hB1);
      resetn = 1'b0;
      #1;
      check_eq("t5_rst_valid", ic_ret_valid, 1'b0);
      check_eq("t5_rst_data", ic_ret_data, 32'h0);
      check_eq("t5_rst_rdreq", mem_rd_req, 1'b0);
      check_eq("t5_rst_addr", mem_rd_addr, 32'h0);
      check_eq("t5_rst_wrrdy", dc_wr_rdy, 1'b0);
      mem_ret_valid = 1'b0; mem_ret_data = '0;
      ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_WORD; ic_rd_addr = 32'h7100;
      #1;
      check_eq("t5_rst_icrdy", ic_rd_rdy, 1'b0);
      tick();
      resetn = 1'b1;
      #1;
      check_eq("t5_first_acc", ic_rd_rdy, 1'b1);
      tick();
      ic_rd_req = 1'b0;
      do_read(OWNER_IC, 32'h7100, RD_TYPE_WORD, 1, 32'h600);

      // 6: back-to-back word reads, one accept every 3 cycles
      dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_WORD; dc_rd_addr = 32'h8000;
      for (int r = 0; r < 3; r++) begin
         #1;
         check_eq($sformatf("t6_acc%0d", r), dc_rd_rdy, 1'b1);
         tick();
         mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hEEEE;
         #1;
         check_eq("t6_req", mem_rd_req, 1'b1);
         check_eq("t6_stray", dc_ret_valid, 1'b0);
         check_eq("t6_gap1", dc_rd_rdy, 1'b0);
         mem_rd_rdy = 1'b1;
         tick();
         mem_rd_rdy = 1'b0;
         mem_ret_data = 32'h700 + r;
         #1;
         check_eq("t6_valid", dc_ret_valid, 1'b1);
         check_eq("t6_last", dc_ret_last, 1'b1);
         check_eq("t6_data", dc_ret_data, 32'h700 + r);
         check_eq("t6_gap2", dc_rd_rdy, 1'b0);
         tick();
         mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
      end
      dc_rd_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
